// File: rtl/compare_sequencer_pkg.sv
// rtl/compare_sequencer_pkg.sv - shared state encodings and mode constants
// Purpose: state encodings for the compare sequencer FSM and the switch mode codes.
package compare_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_COMPARE = 3'd3,
        S_SHOW    = 3'd4,
        S_ERR     = 3'd5
    } state_e;

    localparam logic [1:0] MODE_UNS  = 2'b10;
    localparam logic [1:0] MODE_TWOS = 2'b11;

endpackage

// File: rtl/compare_sequencer_key_pulse.sv
// rtl/compare_sequencer_key_pulse.sv - key synchronizer with single-pulse rising-edge detect
// Purpose: brings a raw asynchronous key level into the clk domain and emits one
//          clk-wide pulse per press, however long the key is held.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   key_raw     raw key level, asynchronous to clk
//   pulse       one-cycle pulse; high during the cycle before the acting edge
module key_pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], key_raw};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Decoded from flops only, so the FSM sees no combinational path from the key pin.
    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/compare_sequencer.sv
// rtl/compare_sequencer.sv - operand entry / compare / result latch sequencer
// Purpose: steps the user through entering operand A and B from switches, drives the
//          comparator, latches its lt/eq/gt result and blinks the operand being entered.
// Ports:
//   clk, reset               system clock, asynchronous active-high reset
//   sw_data, sw_mode         operand value and compare mode from switches
//   key_load, key_clear      raw buttons (asynchronous levels)
//   cmp_lt/eq/gt             comparator results (op_b relative to op_a)
//   op_a, op_b, is_twos      registered comparator operands and mode
//   res_lt/eq/gt, res_valid  latched result for the LEDs
//   err                      invalid mode captured
//   disp_en_a, disp_en_b     HEX enables (blinking while that operand is entered)
//   state_o                  current state encoding
module compare_sequencer
    import compare_sequencer_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_data,
    input  logic [1:0]       sw_mode,
    input  logic             key_load,
    input  logic             key_clear,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             is_twos,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_gt,
    output logic             res_valid,
    output logic             err,
    output logic             disp_en_a,
    output logic             disp_en_b,
    output logic [2:0]       state_o
);

    localparam int              CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic load_pulse, clear_pulse;

    key_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_load (
        .clk(clk), .reset(reset), .key_raw(key_load), .pulse(load_pulse)
    );
    key_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
        .clk(clk), .reset(reset), .key_raw(key_clear), .pulse(clear_pulse)
    );

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic             is_twos_q, is_twos_d;
    logic [2:0]       res_q, res_d;          // {lt, eq, gt}
    logic             res_valid_q, res_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        is_twos_d   = is_twos_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;

        if (clear_pulse) begin
            // Clear beats a simultaneous load; operands are kept.
            state_d     = S_IDLE;
            res_d       = 3'b000;
            res_valid_d = 1'b0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (load_pulse) begin
                    state_d     = S_LOAD_A;
                    res_d       = 3'b000;
                    res_valid_d = 1'b0;
                    err_d       = 1'b0;
                end
                S_LOAD_A: if (load_pulse) begin
                    op_a_d  = sw_data;
                    state_d = S_LOAD_B;
                end
                S_LOAD_B: if (load_pulse) begin
                    op_b_d = sw_data;
                    if (sw_mode == MODE_UNS || sw_mode == MODE_TWOS) begin
                        is_twos_d = (sw_mode == MODE_TWOS);
                        state_d   = S_COMPARE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
                // One settle cycle; loads arriving here are dropped.
                S_COMPARE: begin
                    res_d       = {cmp_lt, cmp_eq, cmp_gt};
                    res_valid_d = 1'b1;
                    state_d     = S_SHOW;
                end
                S_SHOW: if (load_pulse) begin
                    state_d     = S_LOAD_A;
                    res_d       = 3'b000;
                    res_valid_d = 1'b0;
                    err_d       = 1'b0;
                end
                S_ERR: if (load_pulse) begin
                    state_d = S_LOAD_A;
                    err_d   = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Blink timebase restarts on every state change so the newly entered operand
    // always begins visible.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (state_d != state_q) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            is_twos_q   <= 1'b0;
            res_q       <= 3'b000;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            phase_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            is_twos_q   <= is_twos_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign is_twos   = is_twos_q;
    assign res_lt    = res_q[2];
    assign res_eq    = res_q[1];
    assign res_gt    = res_q[0];
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign disp_en_a = (state_q == S_LOAD_A) ? phase_q : 1'b1;
    assign disp_en_b = (state_q == S_LOAD_B) ? phase_q : 1'b1;
    assign state_o   = state_q;

endmodule
